// File: rtl/store_narrow.sv
// Store-data narrowing stage: places a byte/half/word/dword into its byte lanes,
// flags misalignment and signed overflow, and counts overflowing stores.
module store_narrow (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [1:0]  in_size,
    input  logic [2:0]  in_addr_lo,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_wdata,
    output logic [7:0]  out_wstrb,
    output logic        out_ovf,
    output logic        out_misalign,
    output logic [15:0] ovf_cnt,
    input  logic        ovf_clr
);

    logic        accept;
    logic [63:0] dmask;
    logic [7:0]  bmask;
    logic        ovf_d;
    logic        mis_d;
    logic [63:0] wdata_d;
    logic [7:0]  wstrb_d;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Overflow: every bit from the sign bit upward must match.
    always_comb begin
        dmask = '0;
        bmask = '0;
        ovf_d = 1'b0;
        mis_d = 1'b0;
        unique case (in_size)
            2'd0: begin
                dmask = 64'h0000_0000_0000_00FF;
                bmask = 8'h01;
                ovf_d = !((&in_data[63:7]) || !(|in_data[63:7]));
            end
            2'd1: begin
                dmask = 64'h0000_0000_0000_FFFF;
                bmask = 8'h03;
                ovf_d = !((&in_data[63:15]) || !(|in_data[63:15]));
                mis_d = in_addr_lo[0];
            end
            2'd2: begin
                dmask = 64'h0000_0000_FFFF_FFFF;
                bmask = 8'h0F;
                ovf_d = !((&in_data[63:31]) || !(|in_data[63:31]));
                mis_d = |in_addr_lo[1:0];
            end
            default: begin
                dmask = '1;
                bmask = 8'hFF;
                mis_d = |in_addr_lo;
            end
        endcase
    end

    always_comb begin
        wdata_d = '0;
        wstrb_d = '0;
        if (!mis_d) begin
            wdata_d = (in_data & dmask) << {in_addr_lo, 3'b000};
            wstrb_d = bmask << in_addr_lo;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            out_wdata    <= '0;
            out_wstrb    <= '0;
            out_ovf      <= 1'b0;
            out_misalign <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_wdata    <= wdata_d;
            out_wstrb    <= wstrb_d;
            out_ovf      <= ovf_d;
            out_misalign <= mis_d;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt <= '0;
        end else if (ovf_clr) begin
            ovf_cnt <= '0;
        end else if (accept && ovf_d && ovf_cnt != 16'hFFFF) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow: lane placement, flags, handshake,
// counter saturation/clear and asynchronous reset.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_size;
    logic [2:0]  in_addr_lo;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_wdata;
    logic [7:0]  out_wstrb;
    logic        out_ovf;
    logic        out_misalign;
    logic [15:0] ovf_cnt;
    logic        ovf_clr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    store_narrow dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_size     (in_size),
        .in_addr_lo  (in_addr_lo),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_wdata   (out_wdata),
        .out_wstrb   (out_wstrb),
        .out_ovf     (out_ovf),
        .out_misalign(out_misalign),
        .ovf_cnt     (ovf_cnt),
        .ovf_clr     (ovf_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [63:0] d, input logic [7:0] s,
                           input logic o, input logic m);
        chk({tag, ".valid"}, 64'(out_valid), 64'(v));
        chk({tag, ".wdata"}, out_wdata, d);
        chk({tag, ".wstrb"}, 64'(out_wstrb), 64'(s));
        chk({tag, ".ovf"}, 64'(out_ovf), 64'(o));
        chk({tag, ".mis"}, 64'(out_misalign), 64'(m));
    endtask

    task automatic drive(input logic v, input logic [63:0] d,
                         input logic [1:0] sz, input logic [2:0] a);
        in_valid   = v;
        in_data    = d;
        in_size    = sz;
        in_addr_lo = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        drive(1'b0, 64'h0, 2'd0, 3'd0);
        #3;
        chk_out("rst", 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        chk("rst.cnt", 64'(ovf_cnt), 64'h0);
        chk("rst.ready", 64'(in_ready), 64'h1);

        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FF80, 2'd0, 3'd3);
        step();
        chk_out("b3", 1'b1, 64'h0000_0000_8000_0000, 8'h08, 1'b0, 1'b0);

        drive(1'b1, 64'h80, 2'd0, 3'd0);
        step();
        chk_out("b0ovf", 1'b1, 64'h80, 8'h01, 1'b1, 1'b0);
        chk("b0ovf.cnt", 64'(ovf_cnt), 64'd1);

        drive(1'b1, 64'h1234_5678, 2'd2, 3'd4);
        step();
        chk_out("w4", 1'b1, 64'h1234_5678_0000_0000, 8'hF0, 1'b0, 1'b0);

        drive(1'b1, 64'h1234_5678, 2'd1, 3'd1);
        step();
        chk_out("h1mis", 1'b1, 64'h0, 8'h00, 1'b1, 1'b1);
        chk("h1mis.cnt", 64'(ovf_cnt), 64'd2);

        drive(1'b1, 64'hFFFF_FFFF_FFFF_8001, 2'd1, 3'd6);
        step();
        chk_out("h6", 1'b1, 64'h8001_0000_0000_0000, 8'hC0, 1'b0, 1'b0);

        drive(1'b1, 64'h8765_4321_0FED_CBA9, 2'd3, 3'd0);
        step();
        chk_out("d0", 1'b1, 64'h8765_4321_0FED_CBA9, 8'hFF, 1'b0, 1'b0);

        drive(1'b1, 64'h8765_4321_0FED_CBA9, 2'd3, 3'd4);
        step();
        chk_out("d4mis", 1'b1, 64'h0, 8'h00, 1'b0, 1'b1);
        chk("d4mis.cnt", 64'(ovf_cnt), 64'd2);

        drive(1'b1, 64'h0000_0000_7FFF_FFFF, 2'd2, 3'd0);
        step();
        chk_out("wmax", 1'b1, 64'h0000_0000_7FFF_FFFF, 8'h0F, 1'b0, 1'b0);

        // Backpressure: held output must not change for three cycles.
        out_ready = 1'b0;
        drive(1'b1, 64'h11, 2'd0, 3'd0);
        @(negedge clk);
        chk("bp.ready", 64'(in_ready), 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("bp.hold", 1'b1, 64'h0000_0000_7FFF_FFFF, 8'h0F,
                    1'b0, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp.rel", 64'(in_ready), 64'h1);
        step();
        chk_out("b2b0", 1'b1, 64'h11, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 64'h22, 2'd0, 3'd1);
        step();
        chk_out("b2b1", 1'b1, 64'h2200, 8'h02, 1'b0, 1'b0);

        drive(1'b0, 64'h33, 2'd0, 3'd0);
        step();
        chk_out("drain", 1'b0, 64'h2200, 8'h02, 1'b0, 1'b0);

        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr", 64'(ovf_cnt), 64'h0);

        drive(1'b1, 64'h80, 2'd0, 3'd0);
        for (int i = 0; i < 65535; i++) @(posedge clk);
        #1;
        chk("sat.full", 64'(ovf_cnt), 64'hFFFF);
        step();
        chk("sat.hold", 64'(ovf_cnt), 64'hFFFF);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr.win", 64'(ovf_cnt), 64'h0);
        chk_out("clr.out", 1'b1, 64'h80, 8'h01, 1'b1, 1'b0);

        // Asynchronous reset between edges with a result pending.
        out_ready = 1'b0;
        drive(1'b0, 64'h0, 2'd0, 3'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
        chk("arst.cnt", 64'(ovf_cnt), 64'h0);
        chk("arst.ready", 64'(in_ready), 64'h1);

        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 64'hDEAD_BEEF, 2'd2, 3'd0);
        #1;
        chk("post.ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        chk_out("post", 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b1, 1'b0);
        chk("post.cnt", 64'(ovf_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
